serial_shifter: RTL and testbench



---
 rtl/shifter_pkg.sv | 17 +
 rtl/shift_step.sv | 22 ++
 rtl/serial_shifter.sv | 84 ++++++++
 tb/tb_serial_shifter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the serial shift unit: op codes, FSM states, default widths.
package shifter_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SHAMT_W = 5;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift of the accumulator for sll/srl/sra/ror.
module shift_step #(
  parameter int WIDTH = shifter_pkg::DEF_WIDTH
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] acc_next
);
  import shifter_pkg::*;

  always_comb begin
    acc_next = {1'b0, acc[WIDTH-1:1]};
    case (op)
      OP_SLL:  acc_next = {acc[WIDTH-2:0], 1'b0};
      OP_SRL:  acc_next = {1'b0, acc[WIDTH-1:1]};
      OP_SRA:  acc_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
      OP_ROR:  acc_next = {acc[0], acc[WIDTH-1:1]};
      default: acc_next = {1'b0, acc[WIDTH-1:1]};
    endcase
  end

endmodule

// File: rtl/serial_shifter.sv
// One-bit-per-cycle MIPS32 shift unit with start/busy/done handshake.
// The shift operand is truncated to SHAMT_W bits; discarded nonzero upper bits raise trunc.
module serial_shifter #(
  parameter int WIDTH   = shifter_pkg::DEF_WIDTH,
  parameter int SHAMT_W = shifter_pkg::DEF_SHAMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] amount_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             trunc
);
  import shifter_pkg::*;

  state_t             state_reg;
  logic [WIDTH-1:0]   acc_reg;
  logic [WIDTH-1:0]   acc_next;
  logic [SHAMT_W-1:0] cnt_reg;
  logic [1:0]         op_reg;
  logic               trunc_pending_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   result_reg;
  logic               trunc_reg;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_reg),
    .op       (op_reg),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      acc_reg           <= '0;
      cnt_reg           <= '0;
      op_reg            <= '0;
      trunc_pending_reg <= 1'b0;
      busy_reg          <= 1'b0;
      done_reg          <= 1'b0;
      result_reg        <= '0;
      trunc_reg         <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            acc_reg           <= data_in;
            cnt_reg           <= amount_in[SHAMT_W-1:0];
            op_reg            <= op;
            trunc_pending_reg <= |amount_in[WIDTH-1:SHAMT_W];
            busy_reg          <= 1'b1;
            state_reg         <= SHIFT;
          end
        end
        SHIFT: begin
          // The count reaching zero costs one extra cycle, so N=0 still spends one cycle busy.
          if (cnt_reg != '0) begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg - SHAMT_W'(1);
          end else begin
            result_reg <= acc_reg;
            trunc_reg  <= trunc_pending_reg;
            done_reg   <= 1'b1;
            busy_reg   <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign result = result_reg;
  assign trunc  = trunc_reg;

endmodule

// File: tb/tb_serial_shifter.sv
// Directed and randomized checks of serial_shifter against an arithmetic reference model.
module tb_serial_shifter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op_s = 2'b00;
  logic [31:0] data_s = '0;
  logic [31:0] amount_s = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        trunc;

  int vectors = 0;
  int miscompares = 0;

  serial_shifter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op_s),
    .data_in   (data_s),
    .amount_in (amount_s),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .trunc     (trunc)
  );

  always #5 clk = ~clk;

  // Reference: whole-word arithmetic on the truncated count.
  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d,
                                            input logic [31:0] a);
    int n;
    logic [63:0] dd;
    n = int'(a % 32);
    dd = {d, d};
    case (o)
      2'b00:   return d << n;
      2'b01:   return d >> n;
      2'b10:   return 32'($signed(d) >>> n);
      default: begin
        dd = dd >> n;
        return dd[31:0];
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op at a falling edge and wait (bounded) for done; inputs are scrambled after acceptance.
  task automatic run_op(input logic [1:0] o, input logic [31:0] d, input logic [31:0] a,
                        output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; op_s = o; data_s = d; amount_s = a;
    @(negedge clk);
    start = 1'b0; data_s = $urandom; amount_s = $urandom; op_s = 2'($urandom);
    lat = 1;
    bcnt = 0;
    while (!done && lat < 200) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, ndone;
    logic [1:0]  o;
    logic [31:0] d, a;

    // Reset state
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_trunc", 32'(trunc), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Produce a nonzero result so the reset clear is observable
    run_op(2'b11, 32'h1234_5678, 32'd4, lat, bcnt);
    chk("pre_ror_result", result, 32'h8123_4567);

    // Abort mid-operation with reset
    @(negedge clk);
    start = 1'b1; op_s = 2'b00; data_s = 32'h1; amount_s = 32'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run_op(2'b00, 32'h1, 32'h1, lat, bcnt);
    chk("post_rst_result", result, 32'h2);

    // sll by 31: longest op
    run_op(2'b00, 32'h1, 32'h1F, lat, bcnt);
    chk("sll31_result", result, 32'h8000_0000);
    chk("sll31_trunc", 32'(trunc), 32'd0);
    chk("sll31_latency", 32'(lat), 32'd33);
    chk("sll31_busy_cycles", 32'(bcnt), 32'd32);
    chk("sll31_busy_at_done", 32'(busy), 32'd0);

    run_op(2'b10, 32'h8000_0000, 32'd4, lat, bcnt);
    chk("sra4_result", result, 32'hF800_0000);
    run_op(2'b01, 32'h8000_0000, 32'd4, lat, bcnt);
    chk("srl4_result", result, 32'h0800_0000);
    run_op(2'b11, 32'h1, 32'd1, lat, bcnt);
    chk("ror1_result", result, 32'h8000_0000);

    // N=0 via discarded upper bits
    run_op(2'b01, 32'hDEAD_BEEF, 32'h20, lat, bcnt);
    chk("n0_result", result, 32'hDEAD_BEEF);
    chk("n0_trunc", 32'(trunc), 32'd1);
    chk("n0_latency", 32'(lat), 32'd2);
    run_op(2'b00, 32'h3, 32'h21, lat, bcnt);
    chk("amt21_result", result, 32'h6);
    chk("amt21_trunc", 32'(trunc), 32'd1);

    // start held during busy, then a new op accepted in the done cycle
    @(negedge clk);
    start = 1'b1; op_s = 2'b00; data_s = 32'h0000_00A5; amount_s = 32'd8;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!done) begin
        op_s = 2'($urandom); data_s = $urandom; amount_s = $urandom;
      end
    end while (!done && lat < 200);
    chk("hold_result", result, 32'h0000_A500);
    chk("hold_latency", 32'(lat), 32'd10);
    op_s = 2'b01; data_s = 32'hF000_0000; amount_s = 32'd3;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_result_held", result, 32'h0000_A500);
    lat = 1;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_result", result, 32'h1E00_0000);
    chk("b2b_latency", 32'(lat), 32'd5);

    // Randomized regression
    for (int i = 0; i < 1000; i++) begin
      o = 2'($urandom);
      d = $urandom;
      a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
      run_op(o, d, a, lat, bcnt);
      chk($sformatf("rnd%0d_result op=%0d d=%h a=%h", i, o, d, a), result, ref_shift(o, d, a));
      chk($sformatf("rnd%0d_trunc", i), 32'(trunc), 32'(a > 32'd31));
      chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(a % 32) + 32'd2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
